core_porch_queue: RTL and testbench

- Parametrised fetch-to-decode porch: a DEPTH-entry FIFO of fetched instructions with valid/ready handshakes on both sides.
- Replaces the single-register porch stage so fetch can run ahead of a stalled core.
- Flushes in one cycle and evaluates the ARM condition field of the head instruction against the live PSR flags to produce execute/conditional/undefined qualifiers.

---
 rtl/core_porch_queue.sv | 153 +++++++++++++++
 tb/tb_core_porch_queue.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/core_porch_queue.sv
// core_porch_queue: fetch-to-decode porch FIFO with single-cycle flush and
// ARM condition-code qualification of the head instruction.
module core_porch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PC_W      = 30,
  parameter int unsigned DEC_W     = 64,
  parameter bit          COND_EVAL = 1'b1,
  parameter logic [31:0] NOP_INSN  = 32'he1a00000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [PC_W-1:0]          flush_pc,
  input  logic [3:0]               flags,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_insn,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     in_nop,
  input  logic                     in_abort,
  input  logic [DEC_W-1:0]         in_dec,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_insn,
  output logic [PC_W-1:0]          out_pc,
  output logic [DEC_W-1:0]         out_dec,
  output logic                     out_nop,
  output logic                     out_abort,
  output logic                     out_execute,
  output logic                     out_conditional,
  output logic                     out_undefined,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]       insn_mem  [DEPTH];
  logic [PC_W-1:0]   pc_mem    [DEPTH];
  logic [DEC_W-1:0]  dec_mem   [DEPTH];
  logic              nop_mem   [DEPTH];
  logic              abort_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PC_W-1:0]   empty_pc_q, empty_pc_d;

  logic push, pop, head_live, cond_pass;
  logic [3:0] cond;
  logic n_f, z_f, c_f, v_f;

  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != '0);
  assign count     = count_q;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Next-state for pointers, occupancy and the PC shown while empty
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    empty_pc_d = empty_pc_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      empty_pc_d = flush_pc;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_pc_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_pc_q <= empty_pc_d;
    end
  end

  // Entry storage; contents only matter once written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      insn_mem[wr_ptr_q]  <= in_insn;
      pc_mem[wr_ptr_q]    <= in_pc;
      dec_mem[wr_ptr_q]   <= in_dec;
      nop_mem[wr_ptr_q]   <= in_nop;
      abort_mem[wr_ptr_q] <= in_abort;
    end
  end

  // Head fields, with empty-queue substitutes
  always_comb begin
    out_insn  = NOP_INSN;
    out_pc    = empty_pc_q;
    out_dec   = '0;
    out_nop   = 1'b1;
    out_abort = 1'b0;
    if (out_valid) begin
      out_insn  = insn_mem[rd_ptr_q];
      out_pc    = pc_mem[rd_ptr_q];
      out_dec   = dec_mem[rd_ptr_q];
      out_nop   = nop_mem[rd_ptr_q];
      out_abort = abort_mem[rd_ptr_q];
    end
  end

  assign cond = out_insn[31:28];
  assign {n_f, z_f, c_f, v_f} = flags;

  // ARM condition-code pass evaluation against live flags
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'h0: cond_pass = z_f;
      4'h1: cond_pass = !z_f;
      4'h2: cond_pass = c_f;
      4'h3: cond_pass = !c_f;
      4'h4: cond_pass = n_f;
      4'h5: cond_pass = !n_f;
      4'h6: cond_pass = v_f;
      4'h7: cond_pass = !v_f;
      4'h8: cond_pass = c_f && !z_f;
      4'h9: cond_pass = !c_f || z_f;
      4'hA: cond_pass = (n_f == v_f);
      4'hB: cond_pass = (n_f != v_f);
      4'hC: cond_pass = !z_f && (n_f == v_f);
      4'hD: cond_pass = z_f || (n_f != v_f);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
    if (!COND_EVAL) cond_pass = 1'b1;
  end

  assign head_live       = out_valid && !flush;
  assign out_undefined   = head_live && (cond == 4'hF);
  assign out_conditional = head_live && COND_EVAL && (cond != 4'hE);
  assign out_execute     = head_live && !out_nop && !out_abort && !out_undefined && cond_pass;

endmodule

// File: tb/tb_core_porch_queue.sv
// Directed self-checking bench for core_porch_queue (default parameters).
module tb_core_porch_queue;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_nop, in_abort, out_ready;
  logic [29:0] flush_pc, in_pc;
  logic [3:0]  flags;
  logic [31:0] in_insn;
  logic [63:0] in_dec;
  logic        in_ready, out_valid, out_nop, out_abort;
  logic        out_execute, out_conditional, out_undefined;
  logic [31:0] out_insn;
  logic [29:0] out_pc;
  logic [63:0] out_dec;
  logic [2:0]  count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  core_porch_queue #(.DEPTH(4), .PC_W(30), .DEC_W(64), .COND_EVAL(1'b1),
                     .NOP_INSN(32'he1a00000)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc), .flags(flags),
    .in_valid(in_valid), .in_ready(in_ready), .in_insn(in_insn), .in_pc(in_pc),
    .in_nop(in_nop), .in_abort(in_abort), .in_dec(in_dec),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .out_pc(out_pc), .out_dec(out_dec), .out_nop(out_nop), .out_abort(out_abort),
    .out_execute(out_execute), .out_conditional(out_conditional),
    .out_undefined(out_undefined), .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] insn, input logic [29:0] pc,
                       input logic nop, input logic abort);
    in_valid = 1'b1;
    in_insn  = insn;
    in_pc    = pc;
    in_nop   = nop;
    in_abort = abort;
    in_dec   = {32'hDEC0DE00, 2'b00, pc};
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; flush_pc = '0; flags = 4'b0000;
    in_valid = 1'b0; in_insn = '0; in_pc = '0; in_nop = 1'b0; in_abort = 1'b0;
    in_dec = '0; out_ready = 1'b0;
    #12;
    // Reset/idle empty state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_nop", out_nop, 1);
    chk("rst_out_insn", out_insn, 32'he1a00000);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_out_dec", out_dec, 0);
    chk("rst_execute", out_execute, 0);
    rst_n = 1'b1;
    step();

    // Fill with four AL entries, consumer stalled
    for (int i = 0; i < 4; i++) begin
      drive(32'hE0000000 | i, 30'h10 + 30'(i), 1'b0, 1'b0);
      step();
      if (i == 0) chk("lat_head_pc", out_pc, 30'h10);
    end
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    drive(32'hE0000004, 30'h14, 1'b0, 1'b0);
    step();
    chk("fifth_refused", count, 4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("pop_pc", out_pc, 30'h10 + 30'(i));
      chk("pop_dec", out_dec, {32'hDEC0DE00, 2'b00, 30'h10 + 30'(i)});
      chk("pop_execute", out_execute, 1);
      step();
    end
    out_ready = 1'b0;
    chk("drained_count", count, 0);

    // Full queue: simultaneous offer and pop -> pop only
    for (int i = 0; i < 4; i++) begin
      drive(32'hE0000000, 30'h20 + 30'(i), 1'b0, 1'b0);
      step();
    end
    drive(32'hE0000000, 30'h24, 1'b0, 1'b0);
    out_ready = 1'b1;
    step();
    chk("fullpop_count", count, 3);
    chk("fullpop_head", out_pc, 30'h21);
    out_ready = 1'b0;
    chk("fullpop_ready", in_ready, 1);
    step();
    chk("repush_count", count, 4);
    in_valid = 1'b0;
    flush = 1'b1; flush_pc = 30'h100;
    step();
    flush = 1'b0;
    chk("flush1_count", count, 0);
    chk("flush1_pc", out_pc, 30'h100);

    // EQ head
    drive(32'h00000000, 30'h30, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    flags = 4'b0100; #1;
    chk("eq_z1_exec", out_execute, 1);
    chk("eq_cond", out_conditional, 1);
    flags = 4'b0000; #1;
    chk("eq_z0_exec", out_execute, 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // GT head: N==V and !Z passes, Z set fails
    drive(32'hC0000000, 30'h31, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    flags = 4'b1001; #1;
    chk("gt_pass", out_execute, 1);
    flags = 4'b1101; #1;
    chk("gt_fail", out_execute, 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // NV head: undefined
    drive(32'hF0000000, 30'h32, 1'b0, 1'b0);
    step();
    in_valid = 1'b0;
    chk("nv_undef", out_undefined, 1);
    chk("nv_exec", out_execute, 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // AL head with prefetch abort
    drive(32'hE0000000, 30'h33, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("abort_flag", out_abort, 1);
    chk("abort_exec", out_execute, 0);
    chk("al_uncond", out_conditional, 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // AL bubble
    drive(32'hE0000000, 30'h34, 1'b1, 1'b0);
    step();
    in_valid = 1'b0;
    chk("bubble_nop", out_nop, 1);
    chk("bubble_valid", out_valid, 1);
    chk("bubble_exec", out_execute, 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("empty_again", count, 0);

    // Flush with three entries and an offered entry
    for (int i = 0; i < 3; i++) begin
      drive(32'hE0000000, 30'h40 + 30'(i), 1'b0, 1'b0);
      step();
    end
    chk("pre_flush_count", count, 3);
    drive(32'hE0000000, 30'h43, 1'b0, 1'b0);
    flush = 1'b1; flush_pc = 30'h200; out_ready = 1'b1;
    #1;
    chk("flush_qual_low", out_execute, 0);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_pc", out_pc, 30'h200);
    chk("flush_nop", out_nop, 1);
    step();
    chk("flush_dropped", out_valid, 0);

    // Asynchronous reset mid-stream
    drive(32'hE0000000, 30'h50, 1'b0, 1'b0);
    step();
    step();
    in_valid = 1'b0;
    chk("pre_rst_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_insn", out_insn, 32'he1a00000);
    step();
    rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
